// File: rtl/stopwatch_pkg.sv
// Shared types and default constants for the stopwatch control path.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_t;

    localparam int unsigned SW_CLK_HZ   = 50_000_000;
    localparam int unsigned SW_TICK_HZ  = 100;
    localparam int unsigned SW_DIV      = SW_CLK_HZ / SW_TICK_HZ;
    localparam int unsigned SW_DEBOUNCE = (SW_CLK_HZ / 1000) * 20;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Pushbutton front end: 2-flop synchronizer, stability counter and a
// registered one-cycle pulse on each accepted press (debounced 1->0).
module key_debounce
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = SW_DEBOUNCE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int unsigned   CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic          level_dly_q;
    logic          press_q;
    logic          press_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES samples.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        press_d = level_dly_q & ~level_q;
    end

    // Released keys read as 1, so every level flop resets high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            level_q     <= 1'b1;
            level_dly_q <= 1'b1;
            cnt_q       <= '0;
            press_q     <= 1'b0;
        end else begin
            sync1_q     <= key_n;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            level_dly_q <= level_q;
            cnt_q       <= cnt_d;
            press_q     <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/stopwatch_tick_ctrl.sv
// Stopwatch control: debounced keys drive an IDLE/RUN/PAUSE machine and
// a prescaler that emits an exact 100 Hz count-enable tick while running.
module stopwatch_tick_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned DIV             = SW_DIV,
    parameter int unsigned DEBOUNCE_CYCLES = SW_DEBOUNCE
) (
    input  logic CLOCK_50,
    input  logic resetn,
    input  logic key_clear_n,
    input  logic key_run_n,
    output logic tick,
    output logic clear,
    output logic running
);

    localparam int unsigned   PW         = $clog2(DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    logic          clear_press;
    logic          run_press;
    sw_state_t     state_q;
    sw_state_t     state_d;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          tick_q;
    logic          tick_d;
    logic          clear_q;
    logic          clear_d;
    logic          running_q;
    logic          running_d;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_clear_key (
        .clk  (CLOCK_50),
        .rst_n(resetn),
        .key_n(key_clear_n),
        .press(clear_press)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_run_key (
        .clk  (CLOCK_50),
        .rst_n(resetn),
        .key_n(key_run_n),
        .press(run_press)
    );

    // Prescaler advance plus state transitions; a clear press overrides everything.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        clear_d = 1'b0;

        if (state_q == RUN) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                tick_d  = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end else if (state_q == IDLE) begin
            presc_d = '0;
        end

        if (clear_press) begin
            state_d = IDLE;
            clear_d = 1'b1;
            presc_d = '0;
            tick_d  = 1'b0;
        end else if (run_press) begin
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                default: state_d = IDLE;
            endcase
        end

        running_d = (state_d == RUN);
    end

    // State, prescaler and all outputs are registered together.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            tick_q    <= 1'b0;
            clear_q   <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            tick_q    <= tick_d;
            clear_q   <= clear_d;
            running_q <= running_d;
        end
    end

    assign tick    = tick_q;
    assign clear   = clear_q;
    assign running = running_q;

endmodule

// File: tb/tb_stopwatch_tick_ctrl.sv
// Directed bench for stopwatch_tick_ctrl with DIV=10, DEBOUNCE_CYCLES=4.
// Edge numbers are counted from the edge after which a key is first driven.
module tb_stopwatch_tick_ctrl;

    logic CLOCK_50;
    logic resetn;
    logic key_clear_n;
    logic key_run_n;
    logic tick;
    logic clear;
    logic running;

    int errors;
    int checks;
    int edge_no;

    stopwatch_tick_ctrl #(
        .DIV            (10),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .resetn     (resetn),
        .key_clear_n(key_clear_n),
        .key_run_n  (key_run_n),
        .tick       (tick),
        .clear      (clear),
        .running    (running)
    );

    // 50 MHz-style free-running clock (period 10 time units).
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic run_n, input logic clear_n);
        key_run_n   = run_n;
        key_clear_n = clear_n;
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
        edge_no++;
    endtask

    task automatic stepTo(input int target);
        while (edge_no < target) step();
    endtask

    // Hard time limit so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n_tick;
        int n_clear;
        int n_run;
        int pos_err;
        int base;
        int exp_tick;

        errors   = 0;
        checks   = 0;
        edge_no  = 0;
        CLOCK_50 = 1'b0;
        resetn   = 1'b0;
        applyStimulus(1'b1, 1'b1);

        #12;
        checkOutput("rst_tick", int'(tick), 0);
        checkOutput("rst_clear", int'(clear), 0);
        checkOutput("rst_running", int'(running), 0);
        step();
        step();
        resetn = 1'b1;

        // Scenario 1: idle for 100 cycles with keys released.
        n_tick = 0; n_clear = 0; n_run = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (tick) n_tick++;
            if (clear) n_clear++;
            if (running) n_run++;
        end
        checkOutput("idle_tick", n_tick, 0);
        checkOutput("idle_clear", n_clear, 0);
        checkOutput("idle_running", n_run, 0);

        // Scenario 2: run key low for 20 cycles; running at edge 8, ticks at 18,28,...
        edge_no = 0;
        applyStimulus(1'b0, 1'b1);
        stepTo(7);
        checkOutput("t2_running_before", int'(running), 0);
        stepTo(8);
        checkOutput("t2_running_rise", int'(running), 1);
        n_tick = 0; pos_err = 0;
        while (edge_no < 58) begin
            step();
            exp_tick = ((edge_no - 8) % 10 == 0) ? 1 : 0;
            if (int'(tick) != exp_tick) pos_err++;
            if (tick) n_tick++;
            if (edge_no == 20) applyStimulus(1'b1, 1'b1);
        end
        checkOutput("t2_tick_count", n_tick, 5);
        checkOutput("t2_tick_position", pos_err, 0);
        checkOutput("t2_running_hold", int'(running), 1);

        // Scenario 3: pause with prescaler parked at 6, resume, tick 4 cycles later.
        stepTo(66);
        applyStimulus(1'b0, 1'b1);
        stepTo(68);
        checkOutput("t3_tick_before_pause", int'(tick), 1);
        stepTo(73);
        checkOutput("t3_running_before_pause", int'(running), 1);
        stepTo(74);
        checkOutput("t3_running_paused", int'(running), 0);
        checkOutput("t3_tick_at_pause", int'(tick), 0);
        stepTo(76);
        applyStimulus(1'b1, 1'b1);
        n_tick = 0; n_run = 0;
        while (edge_no < 90) begin
            step();
            if (tick) n_tick++;
            if (running) n_run++;
        end
        checkOutput("t3_pause_ticks", n_tick, 0);
        checkOutput("t3_pause_running", n_run, 0);
        applyStimulus(1'b0, 1'b1);
        stepTo(97);
        checkOutput("t3_running_before_resume", int'(running), 0);
        stepTo(98);
        checkOutput("t3_running_resume", int'(running), 1);
        n_tick = 0; pos_err = 0;
        while (edge_no < 112) begin
            step();
            exp_tick = (edge_no == 102 || edge_no == 112) ? 1 : 0;
            if (int'(tick) != exp_tick) pos_err++;
            if (tick) n_tick++;
            if (edge_no == 100) applyStimulus(1'b1, 1'b1);
        end
        checkOutput("t3_resume_tick_position", pos_err, 0);
        checkOutput("t3_resume_tick_count", n_tick, 2);

        // Scenario 5: clear and run together from RUN, landing on a due tick.
        stepTo(122);
        checkOutput("t5_tick_anchor", int'(tick), 1);
        stepTo(124);
        applyStimulus(1'b0, 1'b0);
        stepTo(131);
        checkOutput("t5_clear_before", int'(clear), 0);
        checkOutput("t5_running_before", int'(running), 1);
        stepTo(132);
        checkOutput("t5_clear_pulse", int'(clear), 1);
        checkOutput("t5_running_cleared", int'(running), 0);
        checkOutput("t5_tick_suppressed", int'(tick), 0);
        stepTo(133);
        checkOutput("t5_clear_one_cycle", int'(clear), 0);
        stepTo(134);
        applyStimulus(1'b1, 1'b1);
        n_tick = 0; n_clear = 0; n_run = 0;
        while (edge_no < 150) begin
            step();
            if (tick) n_tick++;
            if (clear) n_clear++;
            if (running) n_run++;
        end
        checkOutput("t5_after_tick", n_tick, 0);
        checkOutput("t5_after_clear", n_clear, 0);
        checkOutput("t5_after_running", n_run, 0);

        // Scenario 4: run key bounce, 3 low / 2 high, five times, from IDLE.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b1);
            repeat (3) step();
            applyStimulus(1'b1, 1'b1);
            repeat (2) step();
        end
        n_tick = 0; n_run = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (tick) n_tick++;
            if (running) n_run++;
        end
        checkOutput("t4_bounce_running", n_run, 0);
        checkOutput("t4_bounce_tick", n_tick, 0);

        // Clear press while already IDLE still pulses clear.
        base = edge_no;
        applyStimulus(1'b1, 1'b0);
        stepTo(base + 7);
        checkOutput("idle_clear_before", int'(clear), 0);
        stepTo(base + 8);
        checkOutput("idle_clear_pulse", int'(clear), 1);
        stepTo(base + 9);
        checkOutput("idle_clear_one_cycle", int'(clear), 0);
        stepTo(base + 10);
        applyStimulus(1'b1, 1'b1);
        stepTo(base + 20);

        // Scenario 6: async reset mid-debounce with the prescaler at 7.
        base = edge_no;
        applyStimulus(1'b0, 1'b1);
        stepTo(base + 14);
        applyStimulus(1'b0, 1'b0);
        stepTo(base + 15);
        checkOutput("t6_running_before_reset", int'(running), 1);
        #2;
        resetn = 1'b0;
        applyStimulus(1'b1, 1'b1);
        #1;
        checkOutput("t6_reset_running", int'(running), 0);
        checkOutput("t6_reset_tick", int'(tick), 0);
        checkOutput("t6_reset_clear", int'(clear), 0);
        repeat (3) step();
        resetn = 1'b1;
        n_tick = 0; n_clear = 0; n_run = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (tick) n_tick++;
            if (clear) n_clear++;
            if (running) n_run++;
        end
        checkOutput("t6_post_reset_pulses", n_tick + n_clear + n_run, 0);

        base = edge_no;
        applyStimulus(1'b0, 1'b1);
        stepTo(base + 8);
        checkOutput("t6_running_rise", int'(running), 1);
        n_tick = 0; pos_err = 0;
        while (edge_no < base + 19) begin
            step();
            exp_tick = (edge_no == base + 18) ? 1 : 0;
            if (int'(tick) != exp_tick) pos_err++;
            if (tick) n_tick++;
            if (edge_no == base + 10) applyStimulus(1'b1, 1'b1);
        end
        checkOutput("t6_first_tick_position", pos_err, 0);
        checkOutput("t6_first_tick_count", n_tick, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
